// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word over valid/ready and shifts it out one bit per clock.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
`endif

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sreg_next;
  logic             head_bit;
  logic             last_bit;
  logic             accept;

  // Shift toward the head bit, filling the vacated end with zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (LSB_FIRST != 0) begin : g_lsb
        if (gi == WIDTH-1) begin : g_fill
          assign sreg_next[gi] = 1'b0;
        end else begin : g_move
          assign sreg_next[gi] = sreg_reg[gi+1];
        end
      end else begin : g_msb
        if (gi == 0) begin : g_fill
          assign sreg_next[gi] = 1'b0;
        end else begin : g_move
          assign sreg_next[gi] = sreg_reg[gi-1];
        end
      end
    end
  endgenerate

  assign head_bit = (LSB_FIRST != 0) ? sreg_reg[0] : sreg_reg[WIDTH-1];
  assign last_bit = (state_reg == S_SHIFT) && (cnt_reg == '0);
  assign accept   = load_valid && load_ready;
  assign busy     = (state_reg != S_IDLE);

`ifdef PISO_PARITY_EN
  logic par_reg;

  assign load_ready = (state_reg == S_IDLE) || (state_reg == S_PAR);
  assign done       = (state_reg == S_PAR);
  assign ser_valid  = (state_reg == S_SHIFT) || (state_reg == S_PAR);
  assign ser_out    = (state_reg == S_SHIFT) ? head_bit :
                      (state_reg == S_PAR)   ? par_reg  : 1'b0;
`else
  assign load_ready = (state_reg == S_IDLE) || last_bit;
  assign done       = last_bit;
  assign ser_valid  = (state_reg == S_SHIFT);
  assign ser_out    = (state_reg == S_SHIFT) ? head_bit : 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      state_reg <= S_SHIFT;
      sreg_reg  <= data_in;
      cnt_reg   <= CW'(WIDTH-1);
    end else begin
      case (state_reg)
        S_SHIFT: begin
          sreg_reg <= sreg_next;
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
`ifdef PISO_PARITY_EN
            state_reg <= S_PAR;
`else
            state_reg <= S_IDLE;
`endif
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is latched at load because the shift register is consumed during the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (accept) begin
      par_reg <= ^data_in;
    end
  end
`endif

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter; the outbound counterpart of the team's parallel-capture shift register.
- Accepts a WIDTH-bit word over a valid/ready load handshake, then emits it one bit per clock with a qualifying valid strobe.
- Back-to-back words stream with no idle gap.
- Sits between a parallel producer (FSM/FIFO) and a serial link or downstream shift-register receiver.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB transmitted first.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- data_in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  block accepts data_in this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid frame bit.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Reset: rst_n low at posedge forces state=IDLE, shift reg=0, bit counter=0. All outputs are driven from registered state: ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1 from the first cycle after reset.
- Reset mid-frame: the frame is abandoned with no partial done. Outputs return to reset values on the next cycle.
- States:
  - IDLE: load_ready=1, ser_valid=0, ser_out=0.
  - SHIFT: ser_valid=1, ser_out = current head bit.
  - PAR: only with PARITY_EN.
- Accept: load_valid && load_ready at a posedge captures data_in into the shift reg, sets counter=WIDTH-1, and enters SHIFT. The first bit appears in the cycle immediately after acceptance (latency 1).
- SHIFT bit selection:
  - Head bit = sreg[WIDTH-1] (MSB-first) or sreg[0] (LSB-first).
  - Each cycle, shift toward the head and fill with 0, then decrement the counter.
- Last bit (counter==0, no parity):
  - done=1.
  - load_ready=1 in the same cycle. A concurrent accept reloads the shift reg and stays in SHIFT, so the next word's first bit follows with zero gap.
  - With no accept, go to IDLE.
- In SHIFT with counter!=0: load_ready=0. load_valid is ignored and data_in is not sampled.
- Counter width: $clog2(WIDTH) bits; no wrap below 0.
- Transitions: IDLE -> SHIFT on accept; SHIFT -> SHIFT (counter!=0, or last bit with accept); SHIFT -> IDLE (last bit, no accept); SHIFT -> PAR (last bit, parity enabled).

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the accepted word, computed at load and held in a register) is sent as bit WIDTH+1 in state PAR with ser_valid=1.
  - done moves to the PAR cycle.
  - Back-to-back acceptance (load_ready=1) moves to the PAR cycle; PAR -> SHIFT on accept, else PAR -> IDLE.
  - The last data bit carries done=0 and load_ready=0.
- Undefined: no PAR state, frame is exactly WIDTH bits, and behaviour is as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with load_valid=1, data_in=8'hFF -> ser_valid=0, ser_out=0, busy=0, done=0 throughout; load_ready=1 on the first cycle after rst_n=1.
- MSB-first single word: accept 8'hA5 at cycle 0 -> cycles 1..8 ser_valid=1, ser_out=1,0,1,0,0,1,0,1; done=1 only at cycle 8; cycle 9 busy=0, ser_valid=0.
- LSB-first (LSB_FIRST=1): accept 8'h01 -> ser_out=1 then seven 0s; done on the 8th bit.
- Back-to-back: load_valid held with 8'hA5 then 8'h3C -> 16 contiguous ser_valid=1 cycles carrying 10100101 00111100; done pulses at bits 8 and 16; load_valid during bits 1..7 ignored.
- Mid-frame reset: accept 8'hA5, assert rst_n=0 after 3 bits -> next cycle ser_valid=0, busy=0, no done. Then accept 8'h80 -> 1 followed by seven 0s.
- Parity (PISO_PARITY_EN):
  - 8'hA5 -> 9 bits 1,0,1,0,0,1,0,1,0; done on bit 9.
  - 8'h07 -> parity bit 1.
